mem_access_unit: RTL

Pipeline-side initiator for the single-port data memory: takes one load/store request from the MEM stage and drives the memory's word address, write data and write enable. The memory reads combinationally and writes on the clock edge, word-wide only. This unit therefore adds byte and halfword access:
- Partial stores run as read-modify-write.
- Sub-word loads are lane-extracted and sign- or zero-extended.
- A ready/valid handshake stalls the pipeline while an access is in flight.

---
 rtl/mem_access_pkg.sv | 26 ++
 rtl/mem_access_if.sv | 39 +++
 rtl/mem_lane_align.sv | 39 +++
 rtl/mem_access_unit.sv | 98 +++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the data-memory access unit:
// access sizes, FSM states and the alignment check.
package mem_access_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  function automatic logic req_bad(
    input logic [1:0] size,
    input logic [1:0] lo
  );
    return (size == SZ_RSVD)
        || (size == SZ_HALF && lo[0])
        || (size == SZ_WORD && lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/response handshake plus word-memory bus
// between the MEM stage, the access unit and the RAM.
interface mem_access_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_pos;
  logic [31:0]       mem_wdata;
  logic              mem_wr;
  logic [31:0]       mem_rdata;

  modport master (
    output req_valid, req_wr, req_size,
    output req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wr, req_size,
    input  req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_pos, mem_wdata, mem_wr,
    input  mem_rdata
  );

  modport mem (
    input  mem_pos, mem_wdata, mem_wr,
    output mem_rdata
  );
endinterface

// File: rtl/mem_lane_align.sv
// Byte/half lane logic: load extract+extend and
// store merge of new data into the old word.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  lo,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ld,
  output logic [31:0] st
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b  = word[{lo, 3'b000} +: 8];
    h  = word[{lo[1], 4'b0000} +: 16];
    ld = word;
    st = wdata;
    unique case (size)
      SZ_BYTE: begin
        ld = {{24{~uns & b[7]}}, b};
        st = word;
        st[{lo, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        ld = {{16{~uns & h[15]}}, h};
        st = word;
        st[{lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: begin
        ld = word;
        st = wdata;
      end
    endcase
  end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for the word-only data RAM;
// sub-word stores are done as read-modify-write.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic         clk,
  input logic         rst_n,
  mem_access_if.slave bus
);
  state_e            state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              wr_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic [31:0]       old_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              bad;
  logic [31:0]       lane_word;
  logic [31:0]       ld;
  logic [31:0]       st;
  logic              busy;

  assign bad  = req_bad(bus.req_size, bus.req_addr[1:0]);
  assign busy = (state == ST_RD) || (state == ST_WR);

  // one aligner: live read data in RD, saved word in WR
  assign lane_word = (state == ST_WR) ? old_q : bus.mem_rdata;

  mem_lane_align u_align (
    .lo   (addr_q[1:0]),
    .size (size_q),
    .uns  (uns_q),
    .word (lane_word),
    .wdata(wdata_q),
    .ld   (ld),
    .st   (st)
  );

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.mem_wr    = (state == ST_WR);
  assign bus.mem_pos   = busy ?
    {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign bus.mem_wdata = (state == ST_WR) ? st : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      old_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            addr_q  <= bus.req_addr;
            size_q  <= bus.req_size;
            wr_q    <= bus.req_wr;
            uns_q   <= bus.req_unsigned;
            wdata_q <= bus.req_wdata;
            err_q   <= bad;
            rdata_q <= '0;
            if (bad)
              state <= ST_RESP;
            else if (bus.req_wr &&
                     bus.req_size == SZ_WORD)
              state <= ST_WR;
            else
              state <= ST_RD;
          end
        end
        ST_RD: begin
          if (wr_q) begin
            old_q <= bus.mem_rdata;
            state <= ST_WR;
          end else begin
            rdata_q <= ld;
            state   <= ST_RESP;
          end
        end
        ST_WR:   state <= ST_RESP;
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
